// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   state_e         : arbiter FSM encoding (idle / load / wait-for-done)
//   TIMEOUT_DEFAULT : default watchdog limit, in WAIT cycles
package uart_pkg;

  localparam int unsigned TIMEOUT_DEFAULT = 1024;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StLoad = 2'd1,
    StWait = 2'd2
  } state_e;

endpackage

// File: rtl/rr_select.sv
// Round-robin selector: picks the first set request bit, searching upward from
// (i_ptr + 1) mod NUM_REQ and wrapping.
//   i_req   : request vector
//   i_ptr   : index of the last grant
//   o_grant : one-hot grant (zero when no request)
//   o_idx   : index of the granted requester (zero when no request)
//   o_any   : at least one request bit is set
module rr_select #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_grant,
  output logic [$clog2(NUM_REQ)-1:0] o_idx,
  output logic                       o_any
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  assign o_any = |i_req;

  always_comb begin : p_sel
    logic            found;
    logic [IdxW-1:0] cand;
    o_grant = '0;
    o_idx   = '0;
    found   = 1'b0;
    cand    = '0;
    // Offsets 1..NUM_REQ so the last owner is examined last.
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(i_ptr) + k) % NUM_REQ);
      if (!found && i_req[cand]) begin
        found         = 1'b1;
        o_grant[cand] = 1'b1;
        o_idx         = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte requesters using round-robin arbitration,
// with a watchdog that abandons a transfer whose tx_done never arrives.
//   i_clk, i_rst  : clock, synchronous active-low reset
//   i_req_valid   : per-requester byte pending
//   i_req_data    : packed bytes, requester i at [i*DATA_W +: DATA_W]
//   o_req_ready   : one-hot accept, combinational, only in IDLE
//   o_tx_start    : one-cycle start pulse (LOAD cycle)
//   o_tx_data     : byte to uart_tx, held from LOAD until back in IDLE
//   i_tx_done     : completion pulse from uart_tx, honoured only in WAIT
//   o_busy        : FSM not in IDLE
//   o_grant_id    : current or last owner
//   o_timeout_err : one-cycle pulse when the watchdog aborts a transfer
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
  output logic [NUM_REQ-1:0]          o_req_ready,
  output logic                        o_tx_start,
  output logic [DATA_W-1:0]           o_tx_data,
  input  logic                        i_tx_done,
  output logic                        o_busy,
  output logic [$clog2(NUM_REQ)-1:0]  o_grant_id,
  output logic                        o_timeout_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);

  state_e            r_state;
  logic [DATA_W-1:0] r_tx_data;
  logic [IdxW-1:0]   r_grant_id;
  logic [IdxW-1:0]   r_ptr;
  logic [WdW-1:0]    r_wd;
  logic              r_tx_start;
  logic              r_timeout_err;

  logic [NUM_REQ-1:0] w_grant;
  logic [IdxW-1:0]    w_idx;
  logic               w_any;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_idle;

  rr_select #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_select (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IdxW'(i)) begin
        w_sel_data = i_req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_idle = (r_state == StIdle);

  // Gated by reset so no byte is consumed on a reset edge.
  assign o_req_ready   = (w_idle && i_rst) ? w_grant : '0;
  assign o_tx_start    = r_tx_start;
  assign o_tx_data     = r_tx_data;
  assign o_busy        = !w_idle;
  assign o_grant_id    = r_grant_id;
  assign o_timeout_err = r_timeout_err;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= StIdle;
      r_tx_data     <= '0;
      r_grant_id    <= '0;
      r_ptr         <= IdxW'(NUM_REQ - 1);
      r_wd          <= '0;
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start    <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_any) begin
            r_tx_data  <= w_sel_data;
            r_grant_id <= w_idx;
            r_ptr      <= w_idx;
            r_wd       <= '0;
            r_tx_start <= 1'b1;
            r_state    <= StLoad;
          end
        end
        StLoad: begin
          r_state <= StWait;
        end
        StWait: begin
          // r_wd counts completed WAIT cycles; abort once TIMEOUT of them pass without done.
          if (i_tx_done) begin
            r_state <= StIdle;
          end else if (r_wd == WdW'(TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= StIdle;
          end else begin
            r_wd <= r_wd + WdW'(1);
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Instance dut uses the default TIMEOUT and
// feeds a transfer scoreboard; instance dut_to uses TIMEOUT=16 for the watchdog case.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        tx_done;

  logic [3:0] req_ready,   t_req_ready;
  logic       tx_start,    t_tx_start;
  logic [7:0] tx_data,     t_tx_data;
  logic       busy,        t_busy;
  logic [1:0] grant_id,    t_grant_id;
  logic       timeout_err, t_timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  int         rdy_cnt[4];
  logic [3:0] pend;

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(req_ready), .o_tx_start(tx_start), .o_tx_data(tx_data),
    .i_tx_done(tx_done), .o_busy(busy), .o_grant_id(grant_id),
    .o_timeout_err(timeout_err)
  );

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_W(8), .TIMEOUT(16)) dut_to (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .i_req_data(req_data),
    .o_req_ready(t_req_ready), .o_tx_start(t_tx_start), .o_tx_data(t_tx_data),
    .i_tx_done(tx_done), .o_busy(t_busy), .o_grant_id(t_grant_id),
    .o_timeout_err(t_timeout_err)
  );

  // Scoreboard monitor on dut: every tx_start must match the next expected transfer.
  always @(negedge clk) begin : p_mon
    exp_t e;
    #2;
    if (rst === 1'b1) begin
      for (int i = 0; i < 4; i++) if (req_valid[i] && req_ready[i]) rdy_cnt[i]++;
      if (req_ready != 4'b0) begin
        n_checks++;
        if ($countones(req_ready) != 1) begin
          $display("FAIL ready_onehot: got %b, required exactly one bit set", req_ready);
          n_fail++;
        end
      end
      if (tx_start === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected_start: got id=%0d data=%h, required no transfer",
                   grant_id, tx_data);
          n_fail++;
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e.data || grant_id !== e.id) begin
            $display("FAIL sb_transfer: got id=%0d data=%h, required id=%0d data=%h",
                     grant_id, tx_data, e.id, e.data);
            n_fail++;
          end
        end
      end
    end
  end

  task automatic push_exp(input int id, input logic [7:0] data);
    exp_t e;
    e.id   = 2'(id);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; req_valid = '0; req_data = '0; tx_done = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) rdy_cnt[i] = 0;
    pend = '0;
  endtask

  // Waits for the next tx_start on dut; optionally drops valid bits once accepted.
  task automatic wait_start(input bit drop, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      @(negedge clk);
      tx_done = 1'b0;
      if (drop) req_valid = req_valid & ~pend;
      pend = '0;
      #2;
      pend = req_valid & req_ready;
      if (tx_start === 1'b1) ok = 1'b1;
    end
    n_checks++;
    if (!ok) begin
      $display("FAIL wait_start: got no tx_start, required one within 60 cycles");
      n_fail++;
    end
  endtask

  // Raises tx_done dly cycles after the current one; wait_start lowers it.
  task automatic pulse_done(input int dly);
    repeat (dly) @(negedge clk);
    tx_done = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 4'hF; req_data = 32'hA3A2_A1A0; tx_done = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    n_checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || timeout_err !== 1'b0 || req_ready !== 4'b0) begin
      $display("FAIL reset_ctrl: got busy=%b start=%b terr=%b ready=%b, required 0/0/0/0000",
               busy, tx_start, timeout_err, req_ready);
      n_fail++;
    end
    n_checks++;
    if (tx_data !== 8'h00 || grant_id !== 2'd0 || t_busy !== 1'b0) begin
      $display("FAIL reset_data: got data=%h id=%0d t_busy=%b, required 00/0/0",
               tx_data, grant_id, t_busy);
      n_fail++;
    end
    rst = 1'b1; tx_done = 1'b0;
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL reset_priority: got ready=%b, required 0001", req_ready);
      n_fail++;
    end
    req_valid = '0;
  endtask

  task automatic test_single();
    int bad = 0;
    do_reset();
    req_data = 32'h0000_0055; req_valid = 4'b0001;
    push_exp(0, 8'h55);
    #2;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL single_ready: got %b, required 0001", req_ready);
      n_fail++;
    end
    @(negedge clk);
    req_valid = '0;
    #2;
    n_checks++;
    if (tx_start !== 1'b1 || tx_data !== 8'h55 || busy !== 1'b1 || req_ready !== 4'b0) begin
      $display("FAIL single_load: got start=%b data=%h busy=%b ready=%b, required 1/55/1/0000",
               tx_start, tx_data, busy, req_ready);
      n_fail++;
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #2;
      if (tx_start !== 1'b0 || busy !== 1'b1 || tx_data !== 8'h55) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      $display("FAIL single_wait: got %0d bad WAIT cycles, required 0", bad);
      n_fail++;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0 || rdy_cnt[0] != 1 || exp_q.size() != 0) begin
      $display("FAIL single_done: got busy=%b rdy=%0d left=%0d, required 0/1/0",
               busy, rdy_cnt[0], exp_q.size());
      n_fail++;
    end
  endtask

  task automatic test_contention();
    bit ok;
    do_reset();
    req_data = 32'hA3A2_A1A0; req_valid = 4'hF;
    for (int i = 0; i < 4; i++) push_exp(i, 8'hA0 + 8'(i));
    #2;
    pend = req_valid & req_ready;
    for (int k = 0; k < 4; k++) begin
      wait_start(1'b1, ok);
      if (!ok) break;
      pulse_done(20);
    end
    @(negedge clk);
    tx_done = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (rdy_cnt[i] != 1) begin
        $display("FAIL contention_ready%0d: got %0d accepts, required 1", i, rdy_cnt[i]);
        n_fail++;
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      $display("FAIL contention_end: got left=%0d busy=%b, required 0/0", exp_q.size(), busy);
      n_fail++;
    end
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    req_data = 32'h3300_1100; req_valid = 4'b1010;
    push_exp(1, 8'h11); push_exp(3, 8'h33); push_exp(1, 8'h11); push_exp(3, 8'h33);
    for (int k = 0; k < 4; k++) begin
      wait_start(1'b0, ok);
      if (!ok) break;
      if (k == 3) req_valid = '0;
      pulse_done(3);
    end
    @(negedge clk);
    tx_done = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0 || busy !== 1'b0 || rdy_cnt[1] != 2 || rdy_cnt[3] != 2) begin
      $display("FAIL fairness: got left=%0d busy=%b r1=%0d r3=%0d, required 0/0/2/2",
               exp_q.size(), busy, rdy_cnt[1], rdy_cnt[3]);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    int first = -1;
    int bad   = 0;
    do_reset();
    req_data = 32'h0000_005A; req_valid = 4'b0001;
    push_exp(0, 8'h5A);
    #2;
    n_checks++;
    if (t_req_ready !== 4'b0001) begin
      $display("FAIL timeout_ready: got %b, required 0001", t_req_ready);
      n_fail++;
    end
    @(negedge clk);
    req_valid = '0;
    #2;
    n_checks++;
    if (t_tx_start !== 1'b1) begin
      $display("FAIL timeout_start: got %b, required 1", t_tx_start);
      n_fail++;
    end
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      #2;
      if (t_timeout_err === 1'b1 && first < 0) first = k;
      if (k <= 16 && t_busy !== 1'b1) bad++;
      if (k == 17) begin
        n_checks++;
        if (t_busy !== 1'b0) begin
          $display("FAIL timeout_idle: got busy=%b, required 0", t_busy);
          n_fail++;
        end
      end
      if (k == 18) begin
        n_checks++;
        if (t_timeout_err !== 1'b0) begin
          $display("FAIL timeout_pulse_len: got %b, required 0", t_timeout_err);
          n_fail++;
        end
      end
    end
    n_checks++;
    if (first != 17 || bad != 0) begin
      $display("FAIL timeout_when: got first=%0d bad=%0d, required 17/0", first, bad);
      n_fail++;
    end
    req_data = 32'h0000_7700; req_valid = 4'b0010;
    #1;
    n_checks++;
    if (t_req_ready !== 4'b0010) begin
      $display("FAIL timeout_next_ready: got %b, required 0010", t_req_ready);
      n_fail++;
    end
    @(negedge clk);
    req_valid = '0;
    #2;
    n_checks++;
    if (t_tx_start !== 1'b1 || t_tx_data !== 8'h77 || t_grant_id !== 2'd1) begin
      $display("FAIL timeout_next: got start=%b data=%h id=%0d, required 1/77/1",
               t_tx_start, t_tx_data, t_grant_id);
      n_fail++;
    end
  endtask

  task automatic test_reset_wait();
    do_reset();
    req_data = 32'h0000_003C; req_valid = 4'b0001;
    push_exp(0, 8'h3C);
    @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    n_checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0 ||
        timeout_err !== 1'b0 || t_timeout_err !== 1'b0 || req_ready !== 4'b0) begin
      $display("FAIL rstwait_outs: got busy=%b start=%b data=%h id=%0d terr=%b/%b, required 0",
               busy, tx_start, tx_data, grant_id, timeout_err, t_timeout_err);
      n_fail++;
    end
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0 || timeout_err !== 1'b0) begin
      $display("FAIL rstwait_late_done: got busy=%b start=%b terr=%b, required 0/0/0",
               busy, tx_start, timeout_err);
      n_fail++;
    end
    req_data = 32'hEE00_00DD; req_valid = 4'b1001;
    push_exp(0, 8'hDD);
    #1;
    n_checks++;
    if (req_ready !== 4'b0001) begin
      $display("FAIL rstwait_ptr: got ready=%b, required 0001", req_ready);
      n_fail++;
    end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL rstwait_sb: got %0d pending, required 0", exp_q.size());
      n_fail++;
    end
  endtask

  task automatic test_spurious_done();
    do_reset();
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0 || tx_start !== 1'b0) begin
      $display("FAIL spurious_idle: got busy=%b start=%b, required 0/0", busy, tx_start);
      n_fail++;
    end
    req_data = 32'h0000_0099; req_valid = 4'b0001;
    push_exp(0, 8'h99);
    @(negedge clk);
    req_valid = '0;
    tx_done   = 1'b1;
    #2;
    n_checks++;
    if (tx_start !== 1'b1) begin
      $display("FAIL spurious_load: got start=%b, required 1", tx_start);
      n_fail++;
    end
    @(negedge clk);
    tx_done = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b1) begin
      $display("FAIL spurious_in_load: got busy=%b, required 1", busy);
      n_fail++;
    end
    repeat (3) @(negedge clk);
    #2;
    n_checks++;
    if (busy !== 1'b1 || tx_data !== 8'h99) begin
      $display("FAIL spurious_wait: got busy=%b data=%h, required 1/99", busy, tx_data);
      n_fail++;
    end
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    #2;
    n_checks++;
    if (busy !== 1'b0 || exp_q.size() != 0) begin
      $display("FAIL spurious_done: got busy=%b left=%0d, required 0/0", busy, exp_q.size());
      n_fail++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end of test, required completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    pend = '0;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_timeout();
    test_reset_wait();
    test_spurious_done();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
